// File: rtl/acq_pkg.sv
// Shared widths, state codes and helpers
// for the acquisition controller.
package acq_pkg;

  localparam int ACQ_DATA_W = 128;
  localparam int ACQ_HOLD_W = 16;
  localparam int DUR_W      = 64;
  localparam int CNT_W      = 32;
  localparam int STATE_W    = 3;
  localparam int THR_W      = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_HOLD = 3'd2,
    ST_DONE = 3'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_acq_controller_if.sv
// AXI-Stream style valid/ready bundle
// shared by the event slot and the bench.
interface axis_acq_controller_if #(
  parameter int W = 128
);

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_event_slot.sv
// One-entry output register; holds a word
// stable until the sink takes it.
module axis_event_slot #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  output logic          free_o,
  axis_acq_controller_if.master m
);

  logic [DW-1:0] data_q;
  logic          valid_q;

  // A full slot can take a new word in the
  // same cycle the sink drains the old one.
  assign free_o   = !valid_q || m.tready;
  assign m.tdata  = data_q;
  assign m.tvalid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (m.tready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_acq_controller.sv
// Run controller: gates reader events into a
// one-word output slot with holdoff and limits.
module axis_acq_controller
  import acq_pkg::*;
#(
  parameter int DATA_WIDTH = ACQ_DATA_W,
  parameter int HOLD_WIDTH = ACQ_HOLD_W
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [DUR_W-1:0]      cfg_duration,
  input  logic [CNT_W-1:0]      cfg_max_events,
  input  logic [HOLD_WIDTH-1:0] cfg_holdoff,
  input  logic [THR_W-1:0]      cfg_threshold,
  output logic [THR_W-1:0]      det_cfg,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_W-1:0]      sts_accepted,
  output logic [CNT_W-1:0]      sts_dropped,
  output logic [STATE_W-1:0]    sts_state,
  output logic                  sts_done
);

  state_e                state_q;
  logic [DUR_W-1:0]      dur_q;
  logic                  dur_en_q;
  logic [HOLD_WIDTH-1:0] hold_cfg_q;
  logic [HOLD_WIDTH-1:0] hold_q;
  logic [CNT_W-1:0]      max_q;
  logic [CNT_W-1:0]      acc_q;
  logic [CNT_W-1:0]      drop_q;
  logic [THR_W-1:0]      thr_q;
  logic                  started_q;

  logic             slot_free;
  logic             active;
  logic             can_start;
  logic             accept;
  logic             drop;
  logic             hit_max;
  logic             dur_end;
  logic [CNT_W-1:0] acc_next;

  axis_acq_controller_if #(.W(DATA_WIDTH)) m_if ();

  axis_event_slot #(.DW(DATA_WIDTH)) u_slot (
    .clk    (aclk),
    .rst    (areset),
    .load_i (accept),
    .data_i (s_axis_tdata),
    .free_o (slot_free),
    .m      (m_if.master)
  );

  assign m_if.tready   = m_axis_tready;
  assign m_axis_tdata  = m_if.tdata;
  assign m_axis_tvalid = m_if.tvalid;

  always_comb begin
    active    = (state_q == ST_RUN) ||
                (state_q == ST_HOLD);
    can_start = cfg_start && !active;
    accept    = (state_q == ST_RUN) &&
                s_axis_tvalid && slot_free &&
                !cfg_stop;
    // Events seen before the first run
    // after reset are not counted.
    drop      = s_axis_tvalid && !accept &&
                started_q && !can_start;
    acc_next  = sat_inc(acc_q);
    hit_max   = accept && (max_q != '0) &&
                (acc_next == max_q);
    dur_end   = active && dur_en_q &&
                (dur_q == DUR_W'(1));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      dur_q      <= '0;
      dur_en_q   <= 1'b0;
      hold_cfg_q <= '0;
      hold_q     <= '0;
      max_q      <= '0;
      acc_q      <= '0;
      drop_q     <= '0;
      thr_q      <= '0;
      started_q  <= 1'b0;
    end else if (can_start) begin
      state_q    <= ST_RUN;
      dur_q      <= cfg_duration;
      dur_en_q   <= (cfg_duration != '0);
      hold_cfg_q <= cfg_holdoff;
      hold_q     <= '0;
      max_q      <= cfg_max_events;
      acc_q      <= '0;
      drop_q     <= '0;
      thr_q      <= cfg_threshold;
      started_q  <= 1'b1;
    end else begin
      if (accept) acc_q <= acc_next;
      if (drop) drop_q <= sat_inc(drop_q);
      if (active && dur_en_q)
        dur_q <= dur_q - DUR_W'(1);
      if (active) begin
        if (cfg_stop || hit_max || dur_end) begin
          state_q <= ST_DONE;
        end else if (accept &&
                     hold_cfg_q != '0) begin
          state_q <= ST_HOLD;
          hold_q  <= hold_cfg_q;
        end else if (state_q == ST_HOLD) begin
          if (hold_q <= HOLD_WIDTH'(1))
            state_q <= ST_RUN;
          else
            hold_q <= hold_q - HOLD_WIDTH'(1);
        end
      end
    end
  end

  assign det_cfg      = thr_q;
  assign sts_accepted = acc_q;
  assign sts_dropped  = drop_q;
  assign sts_state    = state_q;
  assign sts_done     = (state_q == ST_DONE);

endmodule

// File: doc/axis_acq_controller.md
AXIS_ACQ_CONTROLLER -- requirements
Module: axis_acq_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: event word width, {timestamp[127:64], hit mask[63:0]}.
REQ-002 SHALL have parameter HOLD_WIDTH, default 16: holdoff counter width.
REQ-003 SHALL have port aclk, input, 1: single clock for all logic.
REQ-004 SHALL have port areset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_start, input, 1: single-cycle run start pulse.
REQ-006 SHALL have port cfg_stop, input, 1: single-cycle run abort pulse.
REQ-007 SHALL have port cfg_duration, input, 64: run length in aclk cycles; 0 = unlimited.
REQ-008 SHALL have port cfg_max_events, input, 32: accepted-event limit; 0 = unlimited.
REQ-009 SHALL have port cfg_holdoff, input, HOLD_WIDTH: dead-time cycles after each accepted event.
REQ-010 SHALL have port cfg_threshold, input, 3: coincidence threshold request.
REQ-011 SHALL have port det_cfg, output, 3: threshold driven to the detector reader.
REQ-012 SHALL have ports s_axis_tdata (input, DATA_WIDTH) and s_axis_tvalid (input, 1): reader events; no tready, the source cannot stall.
REQ-013 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1) and m_axis_tready (input, 1): forwarded events.
REQ-014 SHALL have ports sts_accepted (output, 32), sts_dropped (output, 32), sts_state (output, 3), sts_done (output, 1).

Function
REQ-015 SHALL implement states IDLE=0, RUN=1, HOLDOFF=2, DONE=3.
REQ-016 In IDLE or DONE, cfg_start SHALL, on the next edge:
- clear sts_accepted and sts_dropped
- load the duration and holdoff configuration
- latch cfg_threshold into det_cfg
- enter RUN
REQ-017 cfg_threshold changes outside a start edge SHALL NOT affect det_cfg.
REQ-018 cfg_start in RUN or HOLDOFF SHALL be ignored.
REQ-019 In RUN, s_axis_tvalid SHALL be accepted when the output slot is empty or m_axis_tready=1 that cycle.
REQ-020 An accepted event SHALL:
- load m_axis_tdata/m_axis_tvalid on the next edge (latency 1)
- increment sts_accepted
- enter HOLDOFF if cfg_holdoff is nonzero, else remain in RUN
REQ-021 Events not accepted SHALL increment sts_dropped. This covers a full slot, HOLDOFF, and IDLE/DONE after the first start.
REQ-022 HOLDOFF SHALL last exactly cfg_holdoff cycles, then return to RUN.
REQ-023 The duration counter SHALL decrement in RUN and HOLDOFF only. Reaching 0 with cfg_duration nonzero SHALL enter DONE.
REQ-024 Reaching cfg_max_events (nonzero) SHALL enter DONE on the same edge that loads the final event.
REQ-025 cfg_stop in RUN or HOLDOFF SHALL enter DONE. A concurrent event SHALL be dropped and counted.
REQ-026 Termination priority SHALL be: stop > max_events > duration.
REQ-027 m_axis_tvalid SHALL hold with stable tdata until m_axis_tready=1. The slot SHALL keep draining in DONE and IDLE.
REQ-028 sts_accepted and sts_dropped SHALL saturate at 32'hFFFFFFFF.
REQ-029 sts_done SHALL be 1 exactly in DONE. sts_state SHALL equal the state code.

Reset
REQ-030 areset SHALL, on any aclk edge including mid-run, force the following; a pending output word SHALL be discarded:
- IDLE
- m_axis_tvalid=0
- m_axis_tdata=0
- det_cfg=0
- counters=0
- sts_done=0

Structure
REQ-031 State codes, DATA_WIDTH and the status widths SHALL live in shared package acq_pkg.
REQ-032 The one-entry output slot SHALL be sub-module axis_event_slot, which has load/tready/tvalid and a free flag.
REQ-033 The block SHALL contain no FIFO or CDC; it sits in the aclk domain downstream of the reader's synchroniser.

Verification
REQ-034 Bench SHALL cover these directed scenarios:
- Scenario 1: start with duration=100, max=0, holdoff=0; events at cycles 10 and 20; tready=1. Expect 2 outputs, accepted=2, DONE at cycle 100.
- Scenario 2: holdoff=5; events at cycles 0 and 3 (dropped) and 6 (accepted). Expect accepted=2, dropped=1.
- Scenario 3: tready=0 with 3 back-to-back events. Expect the first held stable, dropped=2; release tready and expect exactly 1 transfer.
- Scenario 4: max=2, events every cycle. Expect DONE on the edge that loads the 2nd event, all later events dropped.
- Scenario 5: cfg_stop and an event in the same cycle. Expect DONE, event dropped; cfg_start then clears counters and relatches det_cfg.
- Scenario 6: areset mid-HOLDOFF with a pending output. Expect IDLE, m_axis_tvalid=0, counters=0 on the next edge.
